// File: rtl/rv32i_pkg.sv
// Shared rv32i constants and types.
//   XLEN / NREGS / REG_AW : architectural data width, register count, address width
//   reg_addr_t / xlen_t   : register address and data types
//   REG_ZERO              : address of the hard-wired zero register
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rv32i_regfile_sb_if.sv
// Register-file / scoreboard bus between ID+WB (master) and the register file (slave).
//   rd_addr/rd_data/rd_busy : NUM_RD flattened read ports, port i at [i*W +: W]
//   iss_valid/iss_reg/iss_ready : write reservation handshake from ID
//   wb_enable/wb_reg/wb_data    : writeback strobe from WB
//   sb_err                      : sticky writeback-without-reservation flag
interface rv32i_regfile_sb_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   iss_valid;
    logic [AW-1:0]          iss_reg;
    logic                   iss_ready;
    logic                   wb_enable;
    logic [AW-1:0]          wb_reg;
    logic [XLEN-1:0]        wb_data;
    logic                   sb_err;

    modport master (
        output rd_addr, iss_valid, iss_reg, wb_enable, wb_reg, wb_data,
        input  rd_data, rd_busy, iss_ready, sb_err
    );

    modport slave (
        input  rd_addr, iss_valid, iss_reg, wb_enable, wb_reg, wb_data,
        output rd_data, rd_busy, iss_ready, sb_err
    );
endinterface

// File: rtl/rv32i_regfile_sb_counters.sv
// Pending-write scoreboard: one saturating counter per register.
//   clk, reset            : clock, synchronous active-high reset
//   rd_addr -> rd_busy    : per-port RAW hazard lookup (combinational)
//   iss_valid/iss_reg     : reservation request, accepted when iss_ready
//   wb_enable/wb_reg      : writeback, retires one reservation
//   sb_err                : sticky, set by a writeback with nothing pending
module rv32i_sb_counters #(
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int PEND_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_reg,
    input  logic                 wb_enable,
    input  logic [AW-1:0]        wb_reg,
    output logic                 iss_ready,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic                 sb_err
);
    import rv32i_pkg::*;

    localparam int CW = $clog2(PEND_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PEND_MAX);

    logic [CW-1:0] cnt     [NREGS];
    logic [CW-1:0] cnt_nxt [NREGS];
    logic          err_set;

    // A writeback to the same register frees the slot it occupies, so a full
    // counter can still take a reservation in that cycle.
    assign iss_ready = (iss_reg == '0) || (cnt[iss_reg] != CNT_MAX) ||
                       (wb_enable && wb_reg == iss_reg);

    assign err_set = wb_enable && (wb_reg != '0) && (cnt[wb_reg] == '0);

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_nxt[r] = cnt[r];
            if (r != 0) begin
                // Issue and writeback on the same register cancel out.
                if (iss_valid && iss_ready && iss_reg == AW'(r) &&
                    !(wb_enable && wb_reg == AW'(r))) begin
                    if (cnt[r] != CNT_MAX)
                        cnt_nxt[r] = cnt[r] + 1'b1;
                end else if (wb_enable && wb_reg == AW'(r) &&
                             !(iss_valid && iss_ready && iss_reg == AW'(r))) begin
                    if (cnt[r] != '0)
                        cnt_nxt[r] = cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                cnt[r] <= '0;
            sb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                cnt[r] <= cnt_nxt[r];
            sb_err <= sb_err | err_set;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        logic [AW-1:0] a;
        logic          last_wb;
        assign a = rd_addr[i*AW +: AW];
        // With bypass the final writeback is visible this cycle, so the reader need not stall.
        assign last_wb = (BYPASS != 0) && wb_enable && (wb_reg == a) && (cnt[a] == CW'(1));
        assign rd_busy[i] = (cnt[a] != '0) && !last_wb;
    end

endmodule

// File: rtl/rv32i_regfile_sb.sv
// Multi-port integer register file with integrated write-pending scoreboard.
//   clk, reset : clock, synchronous active-high reset
//   rf (slave) : read ports, issue reservation, writeback, hazard/err status
module rv32i_regfile_sb #(
    parameter int XLEN     = rv32i_pkg::XLEN,
    parameter int NREGS    = rv32i_pkg::NREGS,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0,
    parameter int PEND_MAX = 3
) (
    input  logic             clk,
    input  logic             reset,
    rv32i_regfile_sb_if.slave rf
);
    import rv32i_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else if (rf.wb_enable && rf.wb_reg != '0) begin
            regs[rf.wb_reg] <= rf.wb_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] v;

        assign a = rf.rd_addr[i*AW +: AW];

        always_comb begin
            v = regs[a];
            if (a == '0)
                v = '0;
            else if (BYPASS != 0 && rf.wb_enable && rf.wb_reg == a)
                v = rf.wb_data;
        end

        if (READ_REG != 0) begin : g_q
            logic [XLEN-1:0] q;
            always_ff @(posedge clk) begin
                if (reset) q <= '0;
                else       q <= v;
            end
            assign rf.rd_data[i*XLEN +: XLEN] = q;
        end else begin : g_comb
            assign rf.rd_data[i*XLEN +: XLEN] = v;
        end
    end

    rv32i_sb_counters #(
        .NREGS   (NREGS),
        .AW      (AW),
        .NUM_RD  (NUM_RD),
        .BYPASS  (BYPASS),
        .PEND_MAX(PEND_MAX)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rf.rd_addr),
        .iss_valid(rf.iss_valid),
        .iss_reg  (rf.iss_reg),
        .wb_enable(rf.wb_enable),
        .wb_reg   (rf.wb_reg),
        .iss_ready(rf.iss_ready),
        .rd_busy  (rf.rd_busy),
        .sb_err   (rf.sb_err)
    );

endmodule

// File: tb/tb_rv32i_regfile_sb.sv
// Scoreboard bench: two instances share stimulus.
//   A: BYPASS=1, READ_REG=0 (defaults)   B: BYPASS=0, READ_REG=1
module tb_rv32i_regfile_sb;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  p0, p1;
    logic        iss_valid, wb_enable;
    logic [4:0]  iss_reg, wb_reg;
    logic [31:0] wb_data;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          c;
        bit          dut;   // 0 = A, 1 = B
        int          kind;  // 0 rd_data, 1 rd_busy, 2 iss_ready, 3 sb_err
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];

    rv32i_regfile_sb_if #(.XLEN(32), .AW(AW), .NUM_RD(2)) ifa ();
    rv32i_regfile_sb_if #(.XLEN(32), .AW(AW), .NUM_RD(2)) ifb ();

    assign ifa.rd_addr = {p1, p0};   assign ifb.rd_addr = {p1, p0};
    assign ifa.iss_valid = iss_valid; assign ifb.iss_valid = iss_valid;
    assign ifa.iss_reg = iss_reg;     assign ifb.iss_reg = iss_reg;
    assign ifa.wb_enable = wb_enable; assign ifb.wb_enable = wb_enable;
    assign ifa.wb_reg = wb_reg;       assign ifb.wb_reg = wb_reg;
    assign ifa.wb_data = wb_data;     assign ifb.wb_data = wb_data;

    rv32i_regfile_sb #(.NUM_RD(2), .BYPASS(1), .READ_REG(0), .PEND_MAX(3))
        dut_a (.clk(clk), .reset(reset), .rf(ifa));
    rv32i_regfile_sb #(.NUM_RD(2), .BYPASS(0), .READ_REG(1), .PEND_MAX(3))
        dut_b (.clk(clk), .reset(reset), .rf(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_enable = 1'b0;
    endtask

    // Queue an expectation for the current cycle (+dly).
    task automatic chk(input bit d, input int k, input int p, input logic [31:0] e,
                       input string n, input int dly = 0);
        exp_t x;
        x.c = cyc + dly; x.dut = d; x.kind = k; x.port = p; x.exp = e; x.name = n;
        q.push_back(x);
    endtask

    function automatic logic [31:0] actual(input bit d, input int k, input int p);
        logic [63:0] rd;
        logic [1:0]  bz;
        rd = d ? ifb.rd_data : ifa.rd_data;
        bz = d ? ifb.rd_busy : ifa.rd_busy;
        case (k)
            0:       return (p == 0) ? rd[31:0] : rd[63:32];
            1:       return {31'd0, bz[p]};
            2:       return {31'd0, d ? ifb.iss_ready : ifa.iss_ready};
            default: return {31'd0, d ? ifb.sb_err : ifa.sb_err};
        endcase
    endfunction

    // Monitor: every negedge, retire all expectations due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < q.size(); ) begin
                if (q[i].c <= cyc) begin
                    logic [31:0] act;
                    act = actual(q[i].dut, q[i].kind, q[i].port);
                    checks++;
                    if (q[i].c != cyc || act !== q[i].exp) begin
                        errors++;
                        $display("FAIL %s (dut %s, cycle %0d): got %h expected %h",
                                 q[i].name, q[i].dut ? "B" : "A", cyc, act, q[i].exp);
                    end
                    q.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    initial begin
        reset = 1'b1; p0 = '0; p1 = '0; iss_reg = '0; wb_reg = '0; wb_data = '0;
        idle();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1. reset state on all registers / ports, x0 immune to writes
        for (int r = 0; r < 32; r++) begin
            if (r > 0) tick();
            p0 = 5'(r); p1 = 5'(31 - r);
            chk(0, 0, 0, 32'h0, "reset_rd_p0");
            chk(0, 0, 1, 32'h0, "reset_rd_p1");
            chk(1, 0, 0, 32'h0, "reset_rd_p0_reg", 1);
            if (r == 0) begin
                chk(0, 1, 0, 32'h0, "reset_busy");
                chk(0, 2, 0, 32'h1, "reset_iss_ready");
                chk(0, 3, 0, 32'h0, "reset_sb_err");
                chk(1, 3, 0, 32'h0, "reset_sb_err_b");
            end
        end
        tick(); p0 = 0; wb_enable = 1; wb_reg = 0; wb_data = 32'hDEADBEEF;
        chk(0, 0, 0, 32'h0, "x0_write_same");
        tick(); idle();
        chk(0, 0, 0, 32'h0, "x0_write_after");
        chk(1, 0, 0, 32'h0, "x0_write_reg");
        chk(0, 3, 0, 32'h0, "x0_no_err");

        // 2. bypass vs. no bypass on x5
        tick(); iss_valid = 1; iss_reg = 5; p0 = 5; p1 = 5;
        chk(0, 1, 1, 32'h0, "x5_busy_issue_cycle");
        tick(); iss_valid = 0; wb_enable = 1; wb_reg = 5; wb_data = 32'h12345678;
        chk(0, 0, 0, 32'h12345678, "x5_bypass");
        chk(0, 1, 1, 32'h0, "x5_busy_masked");
        chk(1, 1, 1, 32'h1, "x5_busy_nobypass");
        chk(1, 0, 0, 32'h0, "x5_nobypass_old", 1);
        tick(); idle();
        chk(0, 0, 0, 32'h12345678, "x5_after");
        chk(1, 0, 0, 32'h12345678, "x5_after_reg", 1);
        chk(0, 1, 1, 32'h0, "x5_busy_clear");
        chk(1, 1, 1, 32'h0, "x5_busy_clear_b");
        chk(0, 3, 0, 32'h0, "x5_no_err");

        // 3. registered read latency on x7
        tick(); iss_valid = 1; iss_reg = 7; p0 = 0; p1 = 7;
        tick(); iss_valid = 0; wb_enable = 1; wb_reg = 7; wb_data = 32'hA5A5A5A5;
        tick(); idle(); p0 = 7;
        chk(0, 0, 0, 32'hA5A5A5A5, "x7_async");
        chk(1, 0, 0, 32'h0, "x7_reg_not_yet");
        chk(1, 0, 0, 32'hA5A5A5A5, "x7_reg_next", 1);

        // 4. saturation on x3
        p1 = 3;
        tick(); iss_valid = 1; iss_reg = 3;
        chk(0, 2, 0, 32'h1, "x3_iss1_ready");
        tick(); chk(0, 2, 0, 32'h1, "x3_iss2_ready"); chk(0, 1, 1, 32'h1, "x3_busy_cnt1");
        tick(); chk(0, 2, 0, 32'h1, "x3_iss3_ready"); chk(0, 1, 1, 32'h1, "x3_busy_cnt2");
        tick();
        chk(0, 2, 0, 32'h0, "x3_full_ready");
        chk(1, 2, 0, 32'h0, "x3_full_ready_b");
        chk(0, 1, 1, 32'h1, "x3_full_busy");
        tick(); wb_enable = 1; wb_reg = 3; wb_data = 32'h33;
        chk(0, 2, 0, 32'h1, "x3_full_wb_ready");
        chk(0, 1, 1, 32'h1, "x3_full_wb_busy");
        tick(); idle();
        chk(0, 2, 0, 32'h0, "x3_still_full");
        tick(); wb_enable = 1; chk(0, 1, 1, 32'h1, "x3_wb1_busy");
        tick(); chk(0, 1, 1, 32'h1, "x3_wb2_busy");
        tick(); chk(0, 1, 1, 32'h0, "x3_wb3_busy"); chk(1, 1, 1, 32'h1, "x3_wb3_busy_b");
        tick(); idle();
        chk(0, 1, 1, 32'h0, "x3_idle_busy");
        chk(1, 1, 1, 32'h0, "x3_idle_busy_b");
        chk(0, 2, 0, 32'h1, "x3_idle_ready");
        chk(0, 3, 0, 32'h0, "x3_no_err");

        // 5. same-cycle issue+wb on x9, then wb with nothing pending
        tick(); iss_valid = 1; iss_reg = 9; p1 = 9;
        tick(); wb_enable = 1; wb_reg = 9; wb_data = 32'h90;
        chk(0, 1, 1, 32'h0, "x9_both_busy_masked");
        chk(1, 1, 1, 32'h1, "x9_both_busy_b");
        tick(); idle();
        chk(0, 1, 1, 32'h1, "x9_cnt_held");
        chk(1, 1, 1, 32'h1, "x9_cnt_held_b");
        tick(); wb_enable = 1; wb_reg = 9; wb_data = 32'h91;
        tick(); wb_data = 32'h99; p0 = 9;
        chk(0, 3, 0, 32'h0, "x9_err_not_yet");
        chk(0, 0, 0, 32'h99, "x9_err_bypass");
        tick(); idle();
        chk(0, 3, 0, 32'h1, "x9_err_set");
        chk(1, 3, 0, 32'h1, "x9_err_set_b");
        chk(0, 0, 0, 32'h99, "x9_err_data");
        chk(1, 0, 0, 32'h91, "x9_reg_old");
        chk(1, 0, 0, 32'h99, "x9_reg_new", 1);
        chk(0, 1, 1, 32'h0, "x9_not_busy");

        // 6. reset drops data, reservations and error
        tick(); iss_valid = 1; iss_reg = 4; p0 = 4; p1 = 4;
        tick();
        tick(); iss_valid = 0; wb_enable = 1; wb_reg = 4; wb_data = 32'h55;
        tick(); idle();
        chk(0, 0, 0, 32'h55, "x4_pre_reset");
        chk(0, 1, 1, 32'h1, "x4_pre_busy");
        tick(); reset = 1;
        tick(); reset = 0;
        chk(0, 0, 0, 32'h0, "x4_post_rd");
        chk(0, 1, 1, 32'h0, "x4_post_busy");
        chk(0, 3, 0, 32'h0, "post_sb_err");
        chk(0, 2, 0, 32'h1, "post_ready");
        chk(1, 0, 0, 32'h0, "x4_post_rd_b");
        chk(1, 1, 1, 32'h0, "x4_post_busy_b");
        chk(1, 3, 0, 32'h0, "post_sb_err_b");
        chk(1, 0, 0, 32'h0, "x4_post_rd_b2", 1);

        repeat (3) tick();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
